// File: rtl/dict_find.sv
// Dictionary search stage: copies a TIB token into a local buffer, then walks the
// newest-first link chain in 8-bit memory. It returns the opcode and pfa of a match, or a miss.
module dict_find #(
  parameter int          ASZ  = 17,
  parameter int          DSZ  = 8,
  parameter int          TMAX = 31,
  parameter logic [15:0] NIL  = 16'hffff
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [ASZ-1:0] tok_ai,
  input  logic [7:0]     tok_len,
  input  logic [ASZ-1:0] ctx,
  output logic           mem_we,
  output logic [ASZ-1:0] mem_ai,
  output logic [DSZ-1:0] mem_vi,
  input  logic [DSZ-1:0] mem_vo,
  output logic           busy,
  output logic           done,
  output logic           found,
  output logic [7:0]     op,
  output logic [ASZ-1:0] pfa
);

  localparam int IW = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LNK0, S_LNK1, S_LEN, S_CMP, S_OPC, S_FIN
  } state_t;

  state_t         r_state;
  logic           r_ph;
  logic [7:0]     r_len;
  logic [ASZ-1:0] r_cur;
  logic [15:0]    r_nxt;
  logic [IW-1:0]  r_idx;
  logic [15:0]    r_guard;
  logic           r_busy;
  logic           r_done;
  logic           r_found;
  logic [7:0]     r_op;
  logic [ASZ-1:0] r_pfa;
  logic [ASZ-1:0] r_mem_ai;
  logic [DSZ-1:0] r_buf [TMAX];

  logic           w_last;
  logic           w_skip;
  logic           w_end;
  logic [ASZ-1:0] w_nxt_addr;

  assign mem_we = 1'b0;
  assign mem_vi = '0;
  assign mem_ai = r_mem_ai;
  assign busy   = r_busy;
  assign done   = r_done;
  assign found  = r_found;
  assign op     = r_op;
  assign pfa    = r_pfa;

  assign w_last     = (8'(r_idx) == r_len - 8'd1);
  assign w_end      = (r_nxt == NIL) || (r_guard == 16'hffff);
  assign w_nxt_addr = ASZ'(r_nxt);
  // Entry rejected on its length byte or on a character: move on down the chain.
  assign w_skip = r_ph && (((r_state == S_LEN) && (8'(mem_vo) != r_len)) ||
                           ((r_state == S_CMP) && (mem_vo != r_buf[r_idx])));

  // NOTE: the token buffer is plain storage whose contents are don't-care after
  // reset, so it has no reset and lives in its own block.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && r_ph) r_buf[r_idx] <= mem_vo;
  end

  // NOTE: every register here uses <=, so all branches see the pre-edge values
  // and the trailing chain-advance override below wins cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ph     <= 1'b0;
      r_len    <= '0;
      r_cur    <= '0;
      r_nxt    <= '0;
      r_idx    <= '0;
      r_guard  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_found  <= 1'b0;
      r_op     <= '0;
      r_pfa    <= '0;
      r_mem_ai <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len   <= tok_len;
            r_cur   <= ctx;
            r_idx   <= '0;
            r_guard <= '0;
            r_ph    <= 1'b0;
            r_found <= 1'b0;
            r_busy  <= 1'b1;
            if (tok_len == 8'd0 || tok_len > 8'(TMAX) || ctx[15:0] == NIL) begin
              r_state <= S_FIN;
            end else begin
              r_mem_ai <= tok_ai;
              r_state  <= S_LOAD;
            end
          end
        end
        // Each read: phase 0 holds the address, phase 1 captures mem_vo and
        // presents the next address.
        S_LOAD: begin
          r_ph <= ~r_ph;
          if (r_ph) begin
            if (w_last) begin
              r_mem_ai <= r_cur;
              r_state  <= S_LNK0;
            end else begin
              r_idx    <= r_idx + 1'b1;
              r_mem_ai <= r_mem_ai + 1'b1;
            end
          end
        end
        S_LNK0: begin
          r_ph <= ~r_ph;
          if (r_ph) begin
            r_nxt[7:0] <= 8'(mem_vo);
            r_mem_ai   <= r_cur + ASZ'(1);
            r_state    <= S_LNK1;
          end
        end
        S_LNK1: begin
          r_ph <= ~r_ph;
          if (r_ph) begin
            r_nxt[15:8] <= 8'(mem_vo);
            r_mem_ai    <= r_cur + ASZ'(2);
            r_state     <= S_LEN;
          end
        end
        S_LEN: begin
          r_ph <= ~r_ph;
          if (r_ph) begin
            r_idx    <= '0;
            r_mem_ai <= r_mem_ai + 1'b1;
            r_state  <= S_CMP;
          end
        end
        S_CMP: begin
          r_ph <= ~r_ph;
          if (r_ph) begin
            r_mem_ai <= r_mem_ai + 1'b1;
            if (w_last) r_state <= S_OPC;
            else        r_idx   <= r_idx + 1'b1;
          end
        end
        S_OPC: begin
          r_ph <= ~r_ph;
          if (r_ph) begin
            r_op    <= 8'(mem_vo);
            r_pfa   <= r_mem_ai;
            r_found <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_ph    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_skip) begin
        if (w_end) begin
          r_state <= S_FIN;
        end else begin
          r_cur    <= w_nxt_addr;
          r_mem_ai <= w_nxt_addr;
          r_guard  <= r_guard + 16'd1;
          r_state  <= S_LNK0;
        end
      end
    end
  end

endmodule

// File: doc/dict_find.md
Name: dict_find

Overview:
- Dictionary search stage that consumes the linked word list built in shared 8-bit memory and the null-terminated TIB.
- Given a token (address and length in TIB) and the latest-entry pointer ctx, it copies the token into a local buffer, then walks the link chain from ctx.
- Returns the matching word's opcode and parameter-field address, or a miss.
- Sits between the TIB tokenizer (upstream) and the inner interpreter/compiler (downstream), as a master on the 8-bit memory bus.

Parameters:
- ASZ, 17, memory address width (128K space)
- DSZ, 8, memory data width
- TMAX, 31, maximum token length held in the local buffer
- NIL, 'hffff, 16-bit link value terminating the chain

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle request pulse; sampled only in IDLE
- tok_ai  input  ASZ  address of first token character
- tok_len  input  8  token length in bytes
- ctx  input  ASZ  address of latest dictionary entry
- mem_we  output  1  memory write enable; always 0
- mem_ai  output  ASZ  memory address
- mem_vi  output  DSZ  memory write data; always 0
- mem_vo  input  DSZ  memory read data, valid one cycle after address presented
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse
- found  output  1  result flag, valid with done and held until next start
- op  output  8  opcode byte at pfa; valid when found
- pfa  output  ASZ  address of opcode byte of matched entry; valid when found

Behaviour:
- Entry layout at address e:
  - e+0: link low byte; e+1: link high byte.
  - e+2: name length n.
  - e+3 .. e+2+n: name characters.
  - e+3+n: opcode byte (pfa).
- The 16-bit link is zero-extended to ASZ. The chain ends at NIL.
- Memory access: every read takes exactly 2 cycles.
  - Cycle A: drive mem_ai.
  - Cycle B: capture mem_vo.
  - No pipelining; mem_ai holds its value through cycle B.
- Reset: state IDLE; busy=0, done=0, found=0, op=0, pfa=0, mem_ai=0, mem_we=0, mem_vi=0. Token buffer contents are don't-care.
- Reset asserted mid-search aborts within that cycle. No done pulse is issued.
- FSM states: IDLE, LOAD, LNK0, LNK1, LEN, CMP, OPC, FIN.
  - IDLE, start=1:
    - Latch tok_ai, tok_len and cur=ctx.
    - If tok_len==0, tok_len>TMAX, or ctx[15:0]==NIL: go to FIN with found=0.
    - Otherwise go to LOAD.
  - LOAD: read tok_len bytes from tok_ai+i into buf[i], i=0..tok_len-1, then go to LNK0.
  - LNK0 / LNK1: read cur+0 / cur+1 into nxt[7:0] / nxt[15:8].
  - LEN: read cur+2.
    - Equal to tok_len: go to CMP with i=0.
    - Otherwise: go to next entry.
  - CMP: read cur+3+i and compare with buf[i]. Comparison is exact byte compare and case-sensitive.
    - Mismatch: go to next entry.
    - Match, i==tok_len-1: go to OPC.
    - Match otherwise: i++.
  - Next entry:
    - nxt==NIL: go to FIN with found=0.
    - Otherwise: cur=nxt, go to LNK0.
  - OPC: read cur+3+tok_len into op; set pfa=cur+3+tok_len, found=1; go to FIN.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- Latency from the start cycle to done = 1 + 2*tok_len + sum over visited entries of (6 + 2*k + 2*hit) + 1.
  - k = characters compared in that entry, including the mismatching one.
  - hit = 1 only for the matched entry.
  - The immediate-miss path takes exactly 2 cycles (done on start+2).
- start while busy is ignored and has no effect on the current search.
- Search order is newest-first, so the newest of any duplicate names wins.
- Address arithmetic wraps modulo 2^ASZ.
- A loop guard counter of 2^16 entries forces a miss (found=0) to protect against a corrupt chain.

Test Plan:
- Dictionary built from nop, dup, drop, swap, +, - at 0x100 (ctx=0x123); TIB "dup swap +" at 0x0.
- Token (0x0,3) "dup" -> done, found=1, pfa=0x10d, op=DUP opcode; 5 entries visited.
- Token (0x4,4) "swap" -> found=1, pfa=0x11d, op=SWAP opcode. Entry "drop" is never visited by the search.
- Token (0x9,1) "+" -> found=1, pfa=0x122. The length-1 entry "-" is rejected on its first character.
- Token "dupx" (len 4, not in dictionary) -> chain walked to nop, link NIL -> found=0.
- Cases tok_len=0, tok_len=32, or ctx=0xffff -> done exactly 2 cycles after start, found=0, no memory reads.
- Reset during CMP -> next cycle busy=0, no done; a fresh start afterward behaves normally.
- start pulsed while busy -> ignored; the result matches the original request.
